// File: rtl/captura_operandos_if.sv
// Keypad capture handshake between the scanner (master) and the operand capture block (slave).
interface captura_operandos_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] pressed_col_in;
  logic [WIDTH-1:0] pressed_row_in;
  logic             pressed_valid_in;
  logic             ack_read;

  modport master (
    output pressed_col_in,
    output pressed_row_in,
    output pressed_valid_in,
    input  ack_read
  );

  modport slave (
    input  pressed_col_in,
    input  pressed_row_in,
    input  pressed_valid_in,
    output ack_read
  );
endinterface

// File: rtl/captura_operandos.sv
// Keypad event consumer: acknowledges each captured key, builds BCD operands A and B,
// and offers them downstream with a valid/ack handshake.
module captura_operandos #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  captura_operandos_if.slave           kp,
  output logic [4*DIGITS-1:0]          entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count,
  output logic [1:0]                   phase,
  output logic [4*DIGITS-1:0]          operand_a,
  output logic [4*DIGITS-1:0]          operand_b,
  output logic                         op_valid,
  input  logic                         op_ack,
  output logic                         key_ignored
);
  localparam int unsigned EW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned KW = 2 * WIDTH;

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    DONE    = 2'b10
  } phase_e;

  typedef enum logic [1:0] {K_DIGIT, K_STAR, K_HASH, K_BAD} key_e;

  phase_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic           ack_q, ack_d;
  logic           ign_q, ign_d;
  logic           opv_q, opv_d;
  logic [EW-1:0]  entry_q, entry_d;
  logic [EW-1:0]  opa_q, opa_d;
  logic [EW-1:0]  opb_q, opb_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  key_code;
  key_e           key_kind;
  logic [3:0]     key_digit;
  logic           capture;
  logic           take_ack;

  assign key_code = {kp.pressed_col_in, kp.pressed_row_in};
  assign capture  = kp.pressed_valid_in & ~busy_q;
  assign take_ack = op_ack & opv_q;

  // Key decode: {col,row}, MSB of each one-hot field is index 0
  always_comb begin
    key_kind  = K_BAD;
    key_digit = 4'd0;
    case (key_code)
      8'b1000_1000: begin key_kind = K_DIGIT; key_digit = 4'd1; end
      8'b0100_1000: begin key_kind = K_DIGIT; key_digit = 4'd2; end
      8'b0010_1000: begin key_kind = K_DIGIT; key_digit = 4'd3; end
      8'b1000_0100: begin key_kind = K_DIGIT; key_digit = 4'd4; end
      8'b0100_0100: begin key_kind = K_DIGIT; key_digit = 4'd5; end
      8'b0010_0100: begin key_kind = K_DIGIT; key_digit = 4'd6; end
      8'b1000_0010: begin key_kind = K_DIGIT; key_digit = 4'd7; end
      8'b0100_0010: begin key_kind = K_DIGIT; key_digit = 4'd8; end
      8'b0010_0010: begin key_kind = K_DIGIT; key_digit = 4'd9; end
      8'b0100_0001: begin key_kind = K_DIGIT; key_digit = 4'd0; end
      8'b1000_0001: key_kind = K_STAR;
      8'b0010_0001: key_kind = K_HASH;
      default:      key_kind = K_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ENTER_A;
    else        state_q <= state_d;
  end

  // Phase transitions; a downstream ack always lands in ENTER_A
  always_comb begin
    state_d = state_q;
    if (capture) begin
      case (state_q)
        ENTER_A: if (key_kind == K_HASH && cnt_q != '0) state_d = ENTER_B;
        ENTER_B: if (key_kind == K_HASH && cnt_q != '0) state_d = DONE;
        DONE:    if (key_kind == K_STAR) state_d = ENTER_A;
        default: state_d = ENTER_A;
      endcase
    end
    if (take_ack) state_d = ENTER_A;
  end

  // Next values of the registered datapath and handshake outputs
  always_comb begin
    busy_d  = busy_q;
    ack_d   = 1'b0;
    ign_d   = 1'b0;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    opv_d   = opv_q;
    if (!kp.pressed_valid_in) busy_d = 1'b0;
    if (capture) begin
      busy_d = 1'b1;
      ack_d  = 1'b1;
      if (state_q == DONE) begin
        if (key_kind == K_STAR) begin
          opa_d   = '0;
          opb_d   = '0;
          opv_d   = 1'b0;
          entry_d = '0;
          cnt_d   = '0;
        end else begin
          ign_d = 1'b1;
        end
      end else begin
        case (key_kind)
          K_DIGIT: begin
            if (cnt_q < CW'(DIGITS)) begin
              entry_d = {entry_q[EW-5:0], key_digit};
              cnt_d   = cnt_q + CW'(1);
            end else begin
              ign_d = 1'b1;
            end
          end
          K_STAR: begin
            entry_d = '0;
            cnt_d   = '0;
          end
          K_HASH: begin
            if (cnt_q == '0) begin
              ign_d = 1'b1;
            end else begin
              if (state_q == ENTER_A) begin
                opa_d = entry_q;
              end else begin
                opb_d = entry_q;
                opv_d = 1'b1;
              end
              entry_d = '0;
              cnt_d   = '0;
            end
          end
          default: ign_d = 1'b1;
        endcase
      end
    end
    if (take_ack) opv_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      ign_q   <= 1'b0;
      opv_q   <= 1'b0;
      entry_q <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      ign_q   <= ign_d;
      opv_q   <= opv_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign kp.ack_read = ack_q;
  assign key_ignored = ign_q;
  assign entry_bcd   = entry_q;
  assign entry_count = cnt_q;
  assign phase       = state_q;
  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign op_valid    = opv_q;
endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed key sequences plus random traffic, compared every cycle
// against a digit-list model of the operand entry.
module tb_captura_operandos;
  localparam int unsigned WIDTH  = 4;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned EW     = 4 * DIGITS;
  localparam int unsigned CW     = $clog2(DIGITS + 1);
  localparam int          STAR   = 10;
  localparam int          HASH   = 11;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          op_ack = 1'b0;
  logic [EW-1:0] entry_bcd, operand_a, operand_b;
  logic [CW-1:0] entry_count;
  logic [1:0]    phase;
  logic          op_valid, key_ignored;

  captura_operandos_if #(.WIDTH(WIDTH)) kp ();

  captura_operandos #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .kp          (kp),
    .entry_bcd   (entry_bcd),
    .entry_count (entry_count),
    .phase       (phase),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .op_valid    (op_valid),
    .op_ack      (op_ack),
    .key_ignored (key_ignored)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: keypad layout by [row][col], entry as a list of typed digits
  int key_tbl [4][4] = '{'{1, 2, 3, -1}, '{4, 5, 6, -1}, '{7, 8, 9, -1}, '{STAR, 0, HASH, -1}};
  int m_digits[$];
  int m_phase = 0;
  int m_opa = 0, m_opb = 0;
  bit m_busy = 0, m_ack = 0, m_ign = 0, m_opv = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_val();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return v;
  endfunction

  function automatic int decode(input logic [3:0] c, input logic [3:0] r);
    int ci = 0, ri = 0;
    if ($countones(c) != 1 || $countones(r) != 1) return -1;
    for (int i = 0; i < 4; i++) begin
      if (c[3-i]) ci = i;
      if (r[3-i]) ri = i;
    end
    return key_tbl[ri][ci];
  endfunction

  function automatic logic [7:0] code_of(input int k);
    logic [3:0] c = 4'b0000, r = 4'b0000;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (key_tbl[ri][ci] == k) begin
          c = 4'b1000 >> ci;
          r = 4'b1000 >> ri;
        end
    return {c, r};
  endfunction

  task automatic model_step();
    int  key;
    bit  cap, acked;
    if (!rst_n) begin
      m_digits.delete();
      m_phase = 0; m_opa = 0; m_opb = 0;
      m_busy = 0; m_ack = 0; m_ign = 0; m_opv = 0;
      return;
    end
    m_ack = 0;
    m_ign = 0;
    key   = decode(kp.pressed_col_in, kp.pressed_row_in);
    cap   = kp.pressed_valid_in && !m_busy;
    acked = op_ack && m_opv;
    if (!kp.pressed_valid_in) m_busy = 0;
    if (cap) begin
      m_busy = 1;
      m_ack  = 1;
      if (key < 0) begin
        m_ign = 1;
      end else if (key <= 9) begin
        if (m_phase == 2 || m_digits.size() == DIGITS) m_ign = 1;
        else m_digits.push_back(key);
      end else if (key == STAR) begin
        m_digits.delete();
        if (m_phase == 2) begin
          m_opa = 0; m_opb = 0; m_opv = 0; m_phase = 0;
        end
      end else begin
        if (m_phase == 2 || m_digits.size() == 0) begin
          m_ign = 1;
        end else if (m_phase == 0) begin
          m_opa = bcd_val(); m_digits.delete(); m_phase = 1;
        end else begin
          m_opb = bcd_val(); m_digits.delete(); m_phase = 2; m_opv = 1;
        end
      end
    end
    if (acked) begin
      m_opv   = 0;
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    check("ack_read",    32'(kp.ack_read),  32'(m_ack));
    check("key_ignored", 32'(key_ignored),  32'(m_ign));
    check("entry_bcd",   32'(entry_bcd),    32'(bcd_val()));
    check("entry_count", 32'(entry_count),  32'(m_digits.size()));
    check("phase",       32'(phase),        32'(m_phase));
    check("operand_a",   32'(operand_a),    32'(m_opa));
    check("operand_b",   32'(operand_b),    32'(m_opb));
    check("op_valid",    32'(op_valid),     32'(m_opv));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive_key(input int k);
    logic [7:0] code;
    code = code_of(k);
    kp.pressed_col_in   = code[7:4];
    kp.pressed_row_in   = code[3:0];
    kp.pressed_valid_in = 1'b1;
  endtask

  task automatic tap(input int k);
    drive_key(k);
    tick();
  endtask

  task automatic rel();
    kp.pressed_valid_in = 1'b0;
    tick();
  endtask

  initial begin
    int acks;
    kp.pressed_col_in   = 4'b0000;
    kp.pressed_row_in   = 4'b0000;
    kp.pressed_valid_in = 1'b0;
    rst_n  = 1'b0;
    op_ack = 1'b0;
    tick();
    tick();
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_entry", 32'(entry_bcd), 32'd0);
    check("rst_opv", 32'(op_valid), 32'd0);
    check("rst_ack", 32'(kp.ack_read), 32'd0);
    rst_n = 1'b1;

    tap(5);
    check("k5_ack", 32'(kp.ack_read), 32'd1);
    check("k5_entry", 32'(entry_bcd), 32'h005);
    check("k5_cnt", 32'(entry_count), 32'd1);
    rel();
    check("k5_ack_drop", 32'(kp.ack_read), 32'd0);

    tap(STAR); rel();
    tap(1); rel(); tap(2); rel(); tap(3); rel();
    tap(4);
    check("full_ign", 32'(key_ignored), 32'd1);
    check("full_entry", 32'(entry_bcd), 32'h123);
    rel();
    tap(HASH);
    check("a_commit", 32'(operand_a), 32'h123);
    check("a_phase", 32'(phase), 32'd1);
    check("a_cnt", 32'(entry_count), 32'd0);
    rel();

    tap(9); rel(); tap(0); rel();
    tap(HASH);
    check("b_commit", 32'(operand_b), 32'h090);
    check("b_phase", 32'(phase), 32'd2);
    check("b_opv", 32'(op_valid), 32'd1);
    rel();
    tap(7);
    check("done_ign", 32'(key_ignored), 32'd1);
    check("done_opb", 32'(operand_b), 32'h090);
    rel();
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    check("ack_opv", 32'(op_valid), 32'd0);
    check("ack_phase", 32'(phase), 32'd0);
    check("ack_opb", 32'(operand_b), 32'h090);

    drive_key(3);
    acks = 0;
    repeat (10) begin
      tick();
      if (kp.ack_read) acks++;
    end
    check("hold_acks", 32'(acks), 32'd1);
    check("hold_cnt", 32'(entry_count), 32'd1);
    kp.pressed_valid_in = 1'b0;
    tick();
    kp.pressed_valid_in = 1'b1;
    tick();
    check("recap_ack", 32'(kp.ack_read), 32'd1);
    check("recap_cnt", 32'(entry_count), 32'd2);
    rel();

    tap(STAR); rel();
    kp.pressed_col_in = 4'b0001; kp.pressed_row_in = 4'b1000; kp.pressed_valid_in = 1'b1;
    tick();
    check("keyA_ack", 32'(kp.ack_read), 32'd1);
    check("keyA_ign", 32'(key_ignored), 32'd1);
    rel();
    kp.pressed_col_in = 4'b1100; kp.pressed_row_in = 4'b1000; kp.pressed_valid_in = 1'b1;
    tick();
    check("multi_ack", 32'(kp.ack_read), 32'd1);
    check("multi_ign", 32'(key_ignored), 32'd1);
    rel();
    tap(HASH);
    check("hash_empty_ign", 32'(key_ignored), 32'd1);
    check("hash_empty_phase", 32'(phase), 32'd0);
    rel();

    tap(1); rel(); tap(HASH); rel();
    tap(0); rel(); tap(4); rel(); tap(2); rel();
    check("pre_rst_entry", 32'(entry_bcd), 32'h042);
    check("pre_rst_phase", 32'(phase), 32'd1);
    drive_key(HASH);
    rst_n = 1'b0;
    tick();
    check("rst_cap_phase", 32'(phase), 32'd0);
    check("rst_cap_entry", 32'(entry_bcd), 32'd0);
    check("rst_cap_opa", 32'(operand_a), 32'd0);
    check("rst_cap_ack", 32'(kp.ack_read), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ack", 32'(kp.ack_read), 32'd1);
    check("post_rst_ign", 32'(key_ignored), 32'd1);
    rel();

    // Random traffic biased toward legal keys so operands complete regularly
    repeat (4000) begin
      if (kp.pressed_valid_in) begin
        if ($urandom_range(0, 2) != 0) kp.pressed_valid_in = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        int k;
        k = $urandom_range(0, 13);
        if (k <= HASH) begin
          drive_key(k);
        end else begin
          kp.pressed_col_in   = 4'($urandom);
          kp.pressed_row_in   = 4'($urandom);
          kp.pressed_valid_in = 1'b1;
        end
      end
      op_ack = ($urandom_range(0, 3) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
